psram_cmd_sequencer: RTL and testbench
======================================

Name: psram_cmd_sequencer

Overview:
- Sits between the UART command decoder and the PSRAM controller.
- Queues decoded read/write commands in a small FIFO and issues them to the PSRAM controller one at a time.
- Waits for completion, with a timeout, and returns read data to the UART transmitter as a single send request.
- Paces UART transmissions so that no response is lost while the transmitter is still busy.

Parameters:
- FIFO_DEPTH, 4: command queue entries; power of two, at least 2.
- PSRAM_TIMEOUT, 1024: clk_PSRAM cycles to wait for psram_done before aborting.
- TX_GAP_CYCLES, 16384: cycles to hold off after send_uart; covers 2 bytes at 730 cycles/bit plus the transmitter's debounce state.
- ERR_WORD, 16'hDEAD: word sent to the UART when a read times out.

Ports:
- clk_PSRAM  in  1  system clock, 27 MHz; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  one-cycle command strobe (UART quad_start).
- cmd_rw  in  2  1 = write, 2 = read; 0 and 3 are invalid.
- cmd_address  in  23  PSRAM word address.
- cmd_data  in  16  write data; ignored for reads.
- cmd_full  out  1  FIFO full.
- psram_ready  in  1  PSRAM initialisation complete.
- psram_start  out  1  one-cycle operation start pulse.
- psram_read_write  out  2  operation type (1 = write, 2 = read).
- psram_address  out  23  operation address.
- psram_data_in  out  16  write data.
- psram_done  in  1  one-cycle completion pulse.
- psram_data_out  in  16  read data; valid in the psram_done cycle.
- send_uart  out  1  one-cycle transmit request.
- send_msg  out  16  transmit word; held stable until the next send.
- busy  out  1  high whenever the state is not IDLE or the FIFO is not empty.
- timeout_err  out  1  sticky; set on any timeout, cleared only by rst.
- drop_count  out  8  commands rejected on a full FIFO; saturates at 255.
- bad_cmd_count  out  8  invalid cmd_rw codes discarded; saturates at 255.

Behaviour:
- Reset (rst high at a clock edge) clears:
  - FIFO pointers, state (goes to IDLE), counters and timeout_err;
  - psram_start, send_uart, psram_read_write and busy to 0;
  - psram_address, psram_data_in and send_msg to 0.
- Reset mid-operation abandons the in-flight command silently and emits no pulses.
- FIFO push:
  - The entry is {rw, address, data}, 41 bits; pointers are log2(FIFO_DEPTH)+1 bits wide, wrap-around.
  - When cmd_valid is high and the FIFO is not full, the push happens at the clock edge.
  - When cmd_valid is high and the FIFO is full (full evaluated before any same-cycle pop), the command is dropped and drop_count increments.
  - Push and pop in the same cycle are legal, and occupancy is unchanged.
- cmd_full is registered and equals the occupancy == FIFO_DEPTH condition.
- IDLE:
  - If the FIFO is not empty and psram_ready = 1, pop the head entry into the output registers.
  - Invalid rw: discard the entry, increment bad_cmd_count, stay in IDLE, no psram_start.
  - Valid rw: go to ISSUE.
- ISSUE: assert psram_start for exactly 1 cycle, with address, data and rw stable from this cycle until completion; clear the timeout counter; go to WAIT.
- WAIT:
  - On psram_done with a write: go to IDLE.
  - On psram_done with a read: latch psram_data_out into send_msg and go to SEND.
  - If the timeout counter reaches PSRAM_TIMEOUT-1 with no psram_done: set timeout_err; a read loads ERR_WORD into send_msg and goes to SEND; a write goes to IDLE.
  - If psram_done arrives in the same cycle as the timeout, psram_done wins.
- SEND: send_uart = 1 for exactly 1 cycle; go to GAP.
- GAP: count TX_GAP_CYCLES cycles, then go to IDLE. Queued commands may issue only after the gap ends.
- psram_read_write returns to 0 on entering IDLE. psram_address and psram_data_in hold their last values.
- Latency with an empty FIFO and psram_ready = 1:
  - The cmd_valid edge loads the FIFO.
  - IDLE pops in the next cycle.
  - psram_start is high in the second cycle after cmd_valid.
  - send_uart is high in the second cycle after psram_done.
- psram_ready low: commands still queue, and none are issued.

Decomposition:
- Shared package psram_uart_pkg holds:
  - RW_WRITE = 2'd1, RW_READ = 2'd2;
  - ADDR_W = 23, DATA_W = 16;
  - the state encodings IDLE, ISSUE, WAIT, SEND, GAP.
- One sub-module, cmd_fifo: a synchronous FIFO with parameters WIDTH and DEPTH and ports push, pop, din, dout, full, empty.
- The FSM and counters stay in the top level.

Test Plan:
- Read flow:
  - Stimulus: write cmd (rw=1, addr=23'h000123, data=16'hBEEF), then read cmd (rw=2, addr=23'h000123); the PSRAM model returns 16'hBEEF with psram_done 20 cycles after start.
  - Required: two psram_start pulses; send_uart once, with send_msg = 16'hBEEF.
- Overflow: 6 back-to-back cmd_valid strobes with psram_ready = 0 -> 4 queued, cmd_full = 1, drop_count = 2; raising psram_ready issues the 4 commands in order.
- Invalid code: cmd_rw = 0, then cmd_rw = 3, then a valid read -> bad_cmd_count = 2; only the read produces psram_start.
- Timeout: read with no psram_done -> timeout_err = 1 after 1024 cycles in WAIT; send_uart fires with send_msg = 16'hDEAD.
- Pacing: two reads queued back-to-back -> the second psram_start occurs no earlier than 16384 cycles after the first send_uart.
- Reset: rst asserted during WAIT for 1 cycle -> all outputs return to reset values next cycle; a late psram_done causes no send_uart.

Source files
------------

// File: rtl/psram_uart_pkg.sv
// Shared definitions for the UART-to-PSRAM command path.
//   RW_WRITE / RW_READ : operation codes carried on cmd_rw and psram_read_write
//   ADDR_W / DATA_W    : PSRAM word address and data widths
//   state_e            : sequencer states
//   cmd_t              : one queued command, {rw, address, data}
package psram_uart_pkg;

  localparam logic [1:0] RW_WRITE = 2'd1;
  localparam logic [1:0] RW_READ  = 2'd2;

  localparam int ADDR_W  = 23;
  localparam int DATA_W  = 16;
  localparam int ENTRY_W = 2 + ADDR_W + DATA_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    SEND  = 3'd3,
    GAP   = 3'd4
  } state_e;

  typedef struct packed {
    logic [1:0]        rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  function automatic logic rw_valid(input logic [1:0] rw);
    return (rw == RW_WRITE) || (rw == RW_READ);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with registered full/empty flags.
//   clk, rst : clock, synchronous active-high reset (pointers and flags only)
//   push     : write din at the clock edge; ignored while full
//   pop      : advance the read pointer; ignored while empty
//   dout     : head entry (valid while empty is low)
//   full     : occupancy == DEPTH
//   empty    : occupancy == 0
module cmd_fifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [AW:0]      w_wptr_nxt;
  logic [AW:0]      w_rptr_nxt;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;

  assign w_push     = push & ~r_full;
  assign w_pop      = pop & ~r_empty;
  assign w_wptr_nxt = r_wptr + (AW+1)'(w_push);
  assign w_rptr_nxt = r_rptr + (AW+1)'(w_pop);

  // Flags are computed from the next pointers so they are true registers
  // rather than a decode of the current ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_full  <= (w_wptr_nxt[AW] != w_rptr_nxt[AW]) &&
                 (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]);
      r_empty <= (w_wptr_nxt == w_rptr_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= din;
  end

  assign dout  = r_mem[r_rptr[AW-1:0]];
  assign full  = r_full;
  assign empty = r_empty;

endmodule

// File: rtl/psram_cmd_sequencer.sv
// Queues decoded UART commands and issues them to the PSRAM controller one
// at a time, waits for completion (with timeout) and returns read data to the
// UART transmitter, holding off between transmissions.
//   clk_PSRAM, rst          : clock, synchronous active-high reset
//   cmd_valid/rw/address/data: command from the UART decoder; cmd_full = queue full
//   psram_ready             : controller initialised; gates issue only
//   psram_start/read_write/address/data_in : operation to the controller
//   psram_done/data_out     : completion pulse and read data
//   send_uart/send_msg      : one-cycle transmit request and its word
//   busy                    : not IDLE or queue not empty
//   timeout_err             : sticky timeout flag
//   drop_count/bad_cmd_count: saturating error counters
module psram_cmd_sequencer
  import psram_uart_pkg::*;
#(
  parameter int              FIFO_DEPTH    = 4,
  parameter int              PSRAM_TIMEOUT = 1024,
  parameter int              TX_GAP_CYCLES = 16384,
  parameter logic [DATA_W-1:0] ERR_WORD    = 16'hDEAD
) (
  input  logic              clk_PSRAM,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_rw,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              cmd_full,
  input  logic              psram_ready,
  output logic              psram_start,
  output logic [1:0]        psram_read_write,
  output logic [ADDR_W-1:0] psram_address,
  output logic [DATA_W-1:0] psram_data_in,
  input  logic              psram_done,
  input  logic [DATA_W-1:0] psram_data_out,
  output logic              send_uart,
  output logic [DATA_W-1:0] send_msg,
  output logic              busy,
  output logic              timeout_err,
  output logic [7:0]        drop_count,
  output logic [7:0]        bad_cmd_count
);

  localparam int TO_W  = (PSRAM_TIMEOUT > 2) ? $clog2(PSRAM_TIMEOUT) : 1;
  localparam int GAP_W = (TX_GAP_CYCLES > 2) ? $clog2(TX_GAP_CYCLES) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(PSRAM_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TX_GAP_CYCLES - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  cmd_t              w_fifo_din;
  cmd_t              w_fifo_dout;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_start;
  logic              w_timeout;
  logic              w_rd_done;

  logic [1:0]        r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_msg;
  logic              r_send;
  logic [TO_W-1:0]   r_to_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic              r_timeout_err;
  logic [7:0]        r_drop;
  logic [7:0]        r_bad;

  assign w_fifo_din = '{rw: cmd_rw, addr: cmd_address, data: cmd_data};
  // Full is the registered flag from before this edge, so a push against a
  // full queue is dropped even if IDLE pops in the same cycle.
  assign w_push     = cmd_valid & ~w_full;

  cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_PSRAM),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_fifo_din),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk_PSRAM) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_start     = 1'b0;
    w_timeout   = 1'b0;
    w_rd_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty && psram_ready) begin
          w_pop = 1'b1;
          if (rw_valid(w_fifo_dout.rw)) w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_start     = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        // Completion takes priority over a coincident timeout.
        if (psram_done) begin
          w_rd_done   = (r_rw == RW_READ);
          w_state_nxt = (r_rw == RW_READ) ? SEND : IDLE;
        end else if (r_to_cnt == TO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = (r_rw == RW_READ) ? SEND : IDLE;
        end
      end
      SEND: w_state_nxt = GAP;
      GAP: begin
        if (r_gap_cnt == GAP_LAST) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_PSRAM) begin
    if (rst) begin
      r_rw          <= 2'd0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_msg         <= '0;
      r_send        <= 1'b0;
      r_to_cnt      <= '0;
      r_gap_cnt     <= '0;
      r_timeout_err <= 1'b0;
      r_drop        <= 8'd0;
      r_bad         <= 8'd0;
    end else begin
      // The transmit strobe is registered off SEND, landing two cycles after
      // the psram_done that produced the word.
      r_send <= (r_state == SEND);

      if (cmd_valid && w_full && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;

      if (w_pop) begin
        if (rw_valid(w_fifo_dout.rw)) begin
          r_rw    <= w_fifo_dout.rw;
          r_addr  <= w_fifo_dout.addr;
          r_wdata <= w_fifo_dout.data;
        end else if (r_bad != 8'hFF) begin
          r_bad <= r_bad + 8'd1;
        end
      end

      if (r_state == ISSUE)     r_to_cnt <= '0;
      else if (r_state == WAIT) r_to_cnt <= r_to_cnt + TO_W'(1);

      if (w_rd_done)                        r_msg <= psram_data_out;
      else if (w_timeout && r_rw == RW_READ) r_msg <= ERR_WORD;

      if (w_timeout) r_timeout_err <= 1'b1;

      if (r_state == SEND)     r_gap_cnt <= '0;
      else if (r_state == GAP) r_gap_cnt <= r_gap_cnt + GAP_W'(1);

      if (r_state != IDLE && w_state_nxt == IDLE) r_rw <= 2'd0;
    end
  end

  assign cmd_full         = w_full;
  assign psram_start      = w_start;
  assign psram_read_write = r_rw;
  assign psram_address    = r_addr;
  assign psram_data_in    = r_wdata;
  assign send_uart        = r_send;
  assign send_msg         = r_msg;
  assign busy             = (r_state != IDLE) | ~w_empty;
  assign timeout_err      = r_timeout_err;
  assign drop_count       = r_drop;
  assign bad_cmd_count    = r_bad;

endmodule

// File: tb/tb_psram_cmd_sequencer.sv
module tb_psram_cmd_sequencer;
  import psram_uart_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cmd_valid;
  logic [1:0]  cmd_rw;
  logic [22:0] cmd_address;
  logic [15:0] cmd_data;
  logic        cmd_full;
  logic        psram_ready;
  logic        psram_start;
  logic [1:0]  psram_read_write;
  logic [22:0] psram_address;
  logic [15:0] psram_data_in;
  logic        psram_done = 1'b0;
  logic [15:0] psram_data_out = 16'h0;
  logic        send_uart;
  logic [15:0] send_msg;
  logic        busy;
  logic        timeout_err;
  logic [7:0]  drop_count;
  logic [7:0]  bad_cmd_count;

  psram_cmd_sequencer dut (
    .clk_PSRAM        (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid),
    .cmd_rw           (cmd_rw),
    .cmd_address      (cmd_address),
    .cmd_data         (cmd_data),
    .cmd_full         (cmd_full),
    .psram_ready      (psram_ready),
    .psram_start      (psram_start),
    .psram_read_write (psram_read_write),
    .psram_address    (psram_address),
    .psram_data_in    (psram_data_in),
    .psram_done       (psram_done),
    .psram_data_out   (psram_data_out),
    .send_uart        (send_uart),
    .send_msg         (send_msg),
    .busy             (busy),
    .timeout_err      (timeout_err),
    .drop_count       (drop_count),
    .bad_cmd_count    (bad_cmd_count)
  );

  typedef struct {
    logic [1:0]  rw;
    logic [22:0] addr;
    logic [15:0] data;
  } exp_cmd_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  exp_cmd_t    exp_start_q[$];
  logic [15:0] exp_send_q[$];
  int          start_cyc_q[$];
  int          send_cyc_q[$];
  int          n_start = 0;
  int          n_send  = 0;
  int          done_cyc = 0;
  int          cmd_cyc = 0;

  // PSRAM controller model
  logic [15:0] mem [logic [22:0]];
  int          model_cnt   = 0;
  int          model_delay = 20;
  bit          model_en    = 1'b1;
  logic [1:0]  m_rw;
  logic [22:0] m_addr;
  exp_cmd_t    mon_e;
  logic [15:0] mon_msg;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    psram_done = 1'b0;
    if (model_cnt > 0) begin
      model_cnt = model_cnt - 1;
      if (model_cnt == 0) begin
        psram_done     = 1'b1;
        psram_data_out = (m_rw == RW_READ && mem.exists(m_addr)) ? mem[m_addr] : 16'h0;
        done_cyc       = cyc;
      end
    end
    if (psram_start) begin
      n_start++;
      start_cyc_q.push_back(cyc);
      chk("start_expected", 32'(exp_start_q.size() != 0), 32'd1);
      if (exp_start_q.size() != 0) begin
        mon_e = exp_start_q.pop_front();
        chk("start_rw", 32'(psram_read_write), 32'(mon_e.rw));
        chk("start_addr", 32'(psram_address), 32'(mon_e.addr));
        if (mon_e.rw == RW_WRITE) chk("start_wdata", 32'(psram_data_in), 32'(mon_e.data));
      end
      if (psram_read_write == RW_WRITE) mem[psram_address] = psram_data_in;
      m_rw   = psram_read_write;
      m_addr = psram_address;
      if (model_en) model_cnt = model_delay;
    end
    if (send_uart) begin
      n_send++;
      send_cyc_q.push_back(cyc);
      chk("send_expected", 32'(exp_send_q.size() != 0), 32'd1);
      if (exp_send_q.size() != 0) begin
        mon_msg = exp_send_q.pop_front();
        chk("send_msg", 32'(send_msg), 32'(mon_msg));
      end
    end
  end

  // Caller is at a negedge; consecutive calls give back-to-back strobes.
  task automatic send_cmd(input logic [1:0] rw, input logic [22:0] a, input logic [15:0] d);
    cmd_valid   = 1'b1;
    cmd_rw      = rw;
    cmd_address = a;
    cmd_data    = d;
    cmd_cyc     = cyc;
    @(negedge clk);
    cmd_valid   = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while ((busy || model_cnt != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(busy || model_cnt != 0), 32'd0);
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_start"}, 32'(psram_start), 32'd0);
    chk({pfx, "_send"},  32'(send_uart), 32'd0);
    chk({pfx, "_rw"},    32'(psram_read_write), 32'd0);
    chk({pfx, "_addr"},  32'(psram_address), 32'd0);
    chk({pfx, "_wdata"}, 32'(psram_data_in), 32'd0);
    chk({pfx, "_msg"},   32'(send_msg), 32'd0);
    chk({pfx, "_busy"},  32'(busy), 32'd0);
    chk({pfx, "_full"},  32'(cmd_full), 32'd0);
    chk({pfx, "_toerr"}, 32'(timeout_err), 32'd0);
    chk({pfx, "_drop"},  32'(drop_count), 32'd0);
    chk({pfx, "_bad"},   32'(bad_cmd_count), 32'd0);
  endtask

  initial begin
    #(1000000);
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;
    int d0;
    int k;
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_rw      = 2'd0;
    cmd_address = '0;
    cmd_data    = '0;
    psram_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("rst");

    // Read flow: write then read back through the model
    psram_ready = 1'b1;
    start_cyc_q.delete(); send_cyc_q.delete();
    s0 = n_start; d0 = n_send;
    exp_start_q.push_back('{RW_WRITE, 23'h000123, 16'hBEEF});
    exp_start_q.push_back('{RW_READ,  23'h000123, 16'h0000});
    exp_send_q.push_back(16'hBEEF);
    send_cmd(RW_WRITE, 23'h000123, 16'hBEEF);
    k = cmd_cyc;
    send_cmd(RW_READ, 23'h000123, 16'h0000);
    wait_idle(20000, "rd_idle");
    chk("rd_nstart", 32'(n_start - s0), 32'd2);
    chk("rd_nsend", 32'(n_send - d0), 32'd1);
    if (start_cyc_q.size() > 0) chk("rd_start_lat", 32'(start_cyc_q[0] - k), 32'd2);
    if (send_cyc_q.size() > 0) chk("rd_send_lat", 32'(send_cyc_q[0] - done_cyc), 32'd2);

    // Overflow with psram_ready low
    psram_ready = 1'b0;
    s0 = n_start;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) exp_start_q.push_back('{RW_WRITE, 23'(32'h10 + i), 16'(32'h1000 + i)});
      send_cmd(RW_WRITE, 23'(32'h10 + i), 16'(32'h1000 + i));
    end
    @(negedge clk);
    chk("ovf_full", 32'(cmd_full), 32'd1);
    chk("ovf_drop", 32'(drop_count), 32'd2);
    chk("ovf_busy", 32'(busy), 32'd1);
    chk("ovf_held", 32'(n_start - s0), 32'd0);
    psram_ready = 1'b1;
    wait_idle(2000, "ovf_idle");
    chk("ovf_nstart", 32'(n_start - s0), 32'd4);
    chk("ovf_full_clr", 32'(cmd_full), 32'd0);

    // Invalid codes followed by a read that times out
    model_en = 1'b0;
    start_cyc_q.delete(); send_cyc_q.delete();
    s0 = n_start; d0 = n_send;
    exp_start_q.push_back('{RW_READ, 23'h000055, 16'h0000});
    exp_send_q.push_back(16'hDEAD);
    send_cmd(2'd0, 23'h000001, 16'h1111);
    send_cmd(2'd3, 23'h000002, 16'h2222);
    send_cmd(RW_READ, 23'h000055, 16'h0000);
    repeat (3) @(negedge clk);
    chk("inv_bad", 32'(bad_cmd_count), 32'd2);
    chk("to_err_pre", 32'(timeout_err), 32'd0);
    wait_idle(20000, "to_idle");
    chk("inv_nstart", 32'(n_start - s0), 32'd1);
    chk("to_nsend", 32'(n_send - d0), 32'd1);
    chk("to_err", 32'(timeout_err), 32'd1);
    if (start_cyc_q.size() > 0 && send_cyc_q.size() > 0)
      chk("to_lat", 32'(send_cyc_q[0] - start_cyc_q[0]), 32'd1026);
    model_en = 1'b1;

    // Pacing: two queued reads
    start_cyc_q.delete(); send_cyc_q.delete();
    s0 = n_start; d0 = n_send;
    exp_start_q.push_back('{RW_READ, 23'h000123, 16'h0000});
    exp_start_q.push_back('{RW_READ, 23'h000010, 16'h0000});
    exp_send_q.push_back(16'hBEEF);
    exp_send_q.push_back(16'h1000);
    send_cmd(RW_READ, 23'h000123, 16'h0000);
    send_cmd(RW_READ, 23'h000010, 16'h0000);
    wait_idle(40000, "pace_idle");
    chk("pace_nstart", 32'(n_start - s0), 32'd2);
    chk("pace_nsend", 32'(n_send - d0), 32'd2);
    if (start_cyc_q.size() > 1 && send_cyc_q.size() > 0)
      chk("pace_gap", 32'((start_cyc_q[1] - send_cyc_q[0]) >= 16384), 32'd1);

    // Reset during WAIT; late completion must not transmit
    model_delay = 50;
    s0 = n_start;
    exp_start_q.push_back('{RW_READ, 23'h000123, 16'h0000});
    send_cmd(RW_READ, 23'h000123, 16'h0000);
    k = 0;
    while (n_start == s0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("mid_started", 32'(n_start - s0), 32'd1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("mid");
    d0 = n_send;
    repeat (80) @(negedge clk);
    chk("late_nsend", 32'(n_send - d0), 32'd0);
    chk("late_busy", 32'(busy), 32'd0);
    model_delay = 20;

    chk("sb_start_left", 32'(exp_start_q.size()), 32'd0);
    chk("sb_send_left", 32'(exp_send_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
